// File: rtl/fp_adder_arbiter_pkg.sv
// Shared types and constants for the floating-point adder arbiter.
// The watchdog build option is FPA_WATCHDOG_EN (see fp_adder_arbiter.sv).
package fp_adder_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CLEAR = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } arb_state_e;

  // Quiet NaN returned when the watchdog gives up on the adder.
  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Bit positions inside RspFlags = {Timeout, Nan, Inf, Zero}.
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_INF     = 1;
  localparam int FLAG_NAN     = 2;
  localparam int FLAG_TIMEOUT = 3;

endpackage

// File: rtl/fp_adder_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module fp_adder_arbiter_rr_picker #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[wrap(int'(ptr) + i)]) begin
        any = 1'b1;
        idx = IW'(wrap(int'(ptr) + i));
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one multi-cycle FloatingPointAdder among NREQ requesters.
// One operation in flight: IDLE -> ISSUE -> CLEAR -> WAIT -> RESP -> IDLE.
// Handshake: a requester holds ReqValid until it sees its one-cycle
// ReqGrant, then drops or replaces it; the operands were captured on the
// cycle before ReqGrant is visible. RspValid is a one-cycle pulse to the
// granted requester only, with RspResult/RspFlags valid in that cycle.
// Build option FPA_WATCHDOG_EN: give up after TIMEOUT cycles in CLEAR/WAIT
// and answer with a quiet NaN and the Timeout flag.
module fp_adder_arbiter
  import fp_adder_arbiter_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NREQ-1:0]    ReqValid,
  input  logic [NREQ*32-1:0] ReqA,
  input  logic [NREQ*32-1:0] ReqB,
  output logic [NREQ-1:0]    ReqGrant,
  output logic [NREQ-1:0]    RspValid,
  output logic [31:0]        RspResult,
  output logic [3:0]         RspFlags,
  output logic               Busy,
  output logic               AddGo,
  output logic [31:0]        AddA,
  output logic [31:0]        AddB,
  input  logic [31:0]        AddResult,
  input  logic               AddReady,
  input  logic               AddZero,
  input  logic               AddInf,
  input  logic               AddNan,
  output logic [2:0]         DbgState
);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [31:0]     opa_q, opa_d;
  logic [31:0]     opb_q, opb_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [31:0]     result_q, result_d;
  logic [3:0]      flags_q, flags_d;

  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

`ifdef FPA_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{QNAN, 32'(TIMEOUT), 32'(FLAG_TIMEOUT)};
`endif

  fp_adder_arbiter_rr_picker #(.N(NREQ)) u_picker (
    .req   (ReqValid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state, capture and pointer logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    grant_d  = '0;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef FPA_WATCHDOG_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          id_d    = pick_idx;
          opa_d   = ReqA[pick_idx*32 +: 32];
          opb_d   = ReqB[pick_idx*32 +: 32];
          ptr_d   = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CLEAR;
`ifdef FPA_WATCHDOG_EN
        cnt_d   = '0;
`endif
      end
      // The adder drops Ready on the edge after Go; wait for that first.
      ST_CLEAR: if (!AddReady) state_d = ST_WAIT;
      ST_WAIT: begin
        if (AddReady) begin
          result_d           = AddResult;
          flags_d            = '0;
          flags_d[FLAG_ZERO] = AddZero;
          flags_d[FLAG_INF]  = AddInf;
          flags_d[FLAG_NAN]  = AddNan;
          state_d            = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef FPA_WATCHDOG_EN
    if (state_q == ST_CLEAR || state_q == ST_WAIT) begin
      cnt_d = cnt_q + 1'b1;
      if (state_d != ST_RESP && cnt_q == CW'(TIMEOUT - 1)) begin
        state_d               = ST_RESP;
        result_d              = QNAN;
        flags_d               = '0;
        flags_d[FLAG_TIMEOUT] = 1'b1;
        flags_d[FLAG_NAN]     = 1'b1;
      end
    end
`endif
  end

  // State and datapath registers, cleared by synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      grant_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
`ifdef FPA_WATCHDOG_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      grant_q  <= grant_d;
      result_q <= result_d;
      flags_q  <= flags_d;
`ifdef FPA_WATCHDOG_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Response strobe goes only to the captured requester ID.
  always_comb begin
    RspValid = '0;
    if (state_q == ST_RESP) RspValid[id_q] = 1'b1;
  end

  assign ReqGrant  = grant_q;
  assign RspResult = result_q;
  assign RspFlags  = flags_q;
  assign Busy      = (state_q != ST_IDLE);
  assign AddGo     = (state_q == ST_ISSUE);
  assign AddA      = opa_q;
  assign AddB      = opb_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter with a behavioural adder stub.
// Build with FPA_WATCHDOG_EN defined to also exercise the watchdog.
module tb_fp_adder_arbiter;
  import fp_adder_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic               Clock, Reset;
  logic [NREQ-1:0]    ReqValid;
  logic [NREQ*32-1:0] ReqA, ReqB;
  logic [NREQ-1:0]    ReqGrant, RspValid;
  logic [31:0]        RspResult;
  logic [3:0]         RspFlags;
  logic               Busy, AddGo;
  logic [31:0]        AddA, AddB, AddResult;
  logic               AddReady, AddZero, AddInf, AddNan;
  logic [2:0]         DbgState;

  int checks   = 0;
  int failures = 0;
  int go_cnt   = 0;
  int rsp_cnt  = 0;
  logic hang   = 1'b0;
  int stub_cnt;
  logic [NREQ-1:0] exp_q[$];

  fp_adder_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqA(ReqA), .ReqB(ReqB),
    .ReqGrant(ReqGrant), .RspValid(RspValid), .RspResult(RspResult),
    .RspFlags(RspFlags), .Busy(Busy), .AddGo(AddGo), .AddA(AddA), .AddB(AddB),
    .AddResult(AddResult), .AddReady(AddReady), .AddZero(AddZero),
    .AddInf(AddInf), .AddNan(AddNan), .DbgState(DbgState)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // ---------------- adder stub ----------------
  // Returns {result, nan, inf, zero} for the operand pairs used below.
  function automatic logic [34:0] add_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 3'b000};
    if (a == 32'h3F800000 && b == 32'hBF800000) return {32'h00000000, 3'b001};
    if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {32'h7F800000, 3'b010};
    if (a == 32'h40000000 && b == 32'h40000000) return {32'h40800000, 3'b000};
    if (a == 32'h7FC00000)                      return {32'h7FC00000, 3'b100};
    return {32'hDEADBEEF, 3'b000};
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      AddReady  <= 1'b1;
      stub_cnt  <= 0;
      AddResult <= '0;
      {AddNan, AddInf, AddZero} <= 3'b000;
    end else if (AddGo) begin
      AddReady <= 1'b0;
      stub_cnt <= LAT;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !hang) begin
        AddReady <= 1'b1;
        {AddResult, AddNan, AddInf, AddZero} <= add_model(AddA, AddB);
      end
    end
  end

  // Event counters sampled on the active edge, read at the falling edge.
  always @(posedge Clock) begin
    if (AddGo) go_cnt <= go_cnt + 1;
    if (RspValid != '0) rsp_cnt <= rsp_cnt + 1;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_grant(output int gid);
    gid = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge Clock);
      if (ReqGrant != '0) begin
        gid = onehot_idx(ReqGrant);
        check("grant_onehot", 32'($countones(ReqGrant)), 32'd1);
        return;
      end
    end
    check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int rid);
    rid = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clock);
      if (RspValid != '0) begin
        rid = onehot_idx(RspValid);
        check("rsp_onehot", 32'($countones(RspValid)), 32'd1);
        return;
      end
    end
    check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    ReqValid = '0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [3:0]  exp_fl;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int gid, rid, go0, rsp0, n;
    vecs[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1] = '{1, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'b0001};
    vecs[2] = '{2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0010};
    vecs[3] = '{3, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000};
    vecs[4] = '{2, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0100};

    ReqA = '0;
    ReqB = '0;
    do_reset();
    Reset = 1'b1;
    @(negedge Clock);
    // Reset state
    check("rst_grant", 32'(ReqGrant), 32'd0);
    check("rst_rspvalid", 32'(RspValid), 32'd0);
    check("rst_busy_go", {30'd0, Busy, AddGo}, 32'd0);
    check("rst_result", RspResult, 32'd0);
    check("rst_adda", AddA, 32'd0);
    check("rst_state", 32'(DbgState), 32'(ST_IDLE));
    Reset = 1'b0;
    @(negedge Clock);

    // Single-requester operations from the table
    for (int v = 0; v < 5; v++) begin
      ReqA = '0;
      ReqB = '0;
      ReqA[vecs[v].id*32 +: 32] = vecs[v].a;
      ReqB[vecs[v].id*32 +: 32] = vecs[v].b;
      go0 = go_cnt;
      ReqValid = '0;
      ReqValid[vecs[v].id] = 1'b1;
      wait_grant(gid);
      ReqValid = '0;
      check("vec_grant_id", 32'(gid), 32'(vecs[v].id));
      check("vec_go_at_grant", 32'(AddGo), 32'd1);
      wait_rsp(rid);
      check("vec_rsp_id", 32'(rid), 32'(vecs[v].id));
      check("vec_result", RspResult, vecs[v].exp_res);
      check("vec_flags", 32'(RspFlags), 32'(vecs[v].exp_fl));
      check("vec_go_count", 32'(go_cnt - go0), 32'd1);
      if (vecs[v].exp_fl[FLAG_INF]) check("vec_inf_exp", 32'(RspResult[30:23]), 32'hFF);
      @(negedge Clock);
      check("vec_rsp_pulse", 32'(RspValid), 32'd0);
      check("vec_busy_after", 32'(Busy), 32'd0);
    end

    // Reset while waiting on the adder: abort without a response
    ReqA = '0;
    ReqB = '0;
    ReqA[31:0] = 32'h3F800000;
    ReqB[31:0] = 32'h40000000;
    ReqValid = 4'b0001;
    wait_grant(gid);
    ReqValid = '0;
    n = 0;
    while (DbgState != 3'(ST_WAIT) && n < 50) begin
      @(negedge Clock);
      n++;
    end
    check("reach_wait", 32'(DbgState), 32'(ST_WAIT));
    Reset = 1'b1;
    @(negedge Clock);
    check("midrst_grant_rsp", {ReqGrant, RspValid}, 32'd0);
    check("midrst_busy_go", {30'd0, Busy, AddGo}, 32'd0);
    check("midrst_result", RspResult, 32'd0);
    check("midrst_flags", 32'(RspFlags), 32'd0);
    check("midrst_adda", AddA, 32'd0);
    check("midrst_addb", AddB, 32'd0);
    Reset = 1'b0;
    rsp0 = rsp_cnt;
    repeat (10) @(negedge Clock);
    check("midrst_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);

    // All requesters valid continuously: round-robin from pointer 0
    for (int i = 0; i < NREQ; i++) begin
      ReqA[i*32 +: 32] = 32'h3F800000;
      ReqB[i*32 +: 32] = 32'h40000000;
    end
    exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    go0  = go_cnt;
    rsp0 = rsp_cnt;
    ReqValid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(gid);
      check("rr_order", 32'(gid), 32'(exp_q.pop_front()));
      check("rr_no_overlap", 32'(rsp_cnt - rsp0), 32'(k));
      wait_rsp(rid);
      if (k == 4) ReqValid = '0;
      check("rr_rsp_id", 32'(rid), 32'(gid));
      check("rr_result", RspResult, 32'h40400000);
      check("rr_go_count", 32'(go_cnt - go0), 32'(k + 1));
    end
    repeat (3) @(negedge Clock);
    check("rr_idle_after", 32'(Busy), 32'd0);

`ifdef FPA_WATCHDOG_EN
    // Adder never answers: watchdog responds 16 cycles after CLEAR entry
    hang = 1'b1;
    ReqValid = 4'b0010;
    wait_grant(gid);
    ReqValid = '0;
    n = 0;
    while (DbgState != 3'(ST_CLEAR) && n < 10) begin
      @(negedge Clock);
      n++;
    end
    check("wd_reach_clear", 32'(DbgState), 32'(ST_CLEAR));
    n = 0;
    while (RspValid == '0 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    check("wd_latency", 32'(n), 32'd16);
    check("wd_rsp_id", 32'(RspValid), 32'b0010);
    check("wd_result", RspResult, 32'h7FC00000);
    check("wd_flags", 32'(RspFlags), 32'b1100);
    hang = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
